lotr_mmio_initiator: RTL and testbench
======================================

Name: lotr_mmio_initiator

Overview:
Fabric-side initiator for the F2C MMIO request/response protocol. It accepts one CR access at a time from a local client (a debug sequencer or core-side bridge) and drives a single-cycle RD or WR request toward the DE10-Lite MMIO responder. It then waits for the matching response and returns read data and a status to the client. A timeout/retry engine and a stray-response counter cover lost or unexpected responses.

Parameters:
TIMEOUT_CYCLES, 16, cycles after the request cycle before the outstanding request is declared lost (≥4)
RETRY_MAX, 1, number of re-issues after a timeout before reporting failure (0..7)

Ports:
CLK_50  in  1  clock
RstQnnnH  in  1  asynchronous reset, active-low (0 = reset)
CmdValid  in  1  client command valid
CmdReady  out  1  initiator can accept a command
CmdOpcode  in  t_opcode  RD or WR
CmdAddress  in  32  CR address; [19:0] is the CR offset
CmdData  in  32  write data
DoneValid  out  1  one-cycle completion pulse
DoneStatus  out  2  00 OK, 01 timeout, 10 illegal opcode
DoneData  out  32  read data; 0 for WR, timeout or error
StrayCnt  out  8  saturating count of unmatched responses
F2C_ReqValidQ500H  out  1  request valid
F2C_ReqOpcodeQ500H  out  t_opcode  request opcode
F2C_ReqAddressQ500H  out  32  request address
F2C_ReqDataQ500H  out  32  request data
F2C_RspValidQ502H  in  1  response valid
F2C_RspOpcodeQ502H  in  t_opcode  response opcode (always RD_RSP)
F2C_RspAddressQ502H  in  32  echoed request address
F2C_RspDataQ502H  in  32  response data

Behaviour:
- Reset (async): state IDLE. All outputs, timer, retry counter, captured command and StrayCnt are 0, including CmdReady. CmdReady rises on the first clock edge after reset release.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - CmdReady=1.
  - On CmdValid, capture opcode/address/data and drop CmdReady the next cycle.
  - RD/WR go to REQ.
  - Any other opcode goes to DONE with status 10; no fabric request is issued.
- REQ:
  - F2C_ReqValidQ500H=1 for exactly one cycle with the captured opcode, address and data.
  - Load the timer with TIMEOUT_CYCLES; go to WAIT.
  - Req address/data/opcode hold their last value when valid=0.
- WAIT:
  - Match condition: RspValid, RspOpcode==RD_RSP, and RspAddress[19:0]==captured[19:0].
  - On match: DoneData = RspData for RD, 0 for WR; status 00; go to DONE.
  - Otherwise decrement the timer.
  - When the timer reaches 0 with no match: if retries used < RETRY_MAX, increment retries and go to REQ (re-issue). Otherwise status 01, DoneData 0, go to DONE.
  - A matching response in the same cycle the timer reaches 0 wins; no timeout is reported.
- DONE: DoneValid=1 for one cycle; clear the retry count; go to IDLE. CmdReady=1 the following cycle.
- Throughput: a new command can be accepted no earlier than the cycle after the DoneValid pulse.
- Stray responses: any RspValid not consumed as a match increments StrayCnt. This includes responses seen in IDLE, REQ or DONE, non-matching responses in WAIT, and late duplicates after a retry. StrayCnt saturates at 255.
- Only one request is outstanding at a time. A response to an earlier timed-out attempt that arrives in WAIT after a retry is accepted as the match (RD and WR are idempotent in the CR space).
- Reset asserted mid-transaction aborts immediately: no DoneValid, ReqValid forced to 0.
- Nominal responder latency is 3 cycles. Relative to command acceptance at cycle T: ReqValid at T+1, RspValid at T+4, DoneValid at T+5.

Test Plan:
- WR LED: CmdOpcode=WR, addr offset CR_LED, data 0x3FF accepted at T. ReqValid at T+1 only, response at T+4 -> DoneValid at T+5, status 00, DoneData 0, StrayCnt 0.
- RD Switch: Switch=0x2A5 on the responder, RD at offset CR_Switch -> DoneData 0x000002A5, status 00, DoneValid 5 cycles after accept.
- Lost response: the model drops all responses, RETRY_MAX=1, TIMEOUT_CYCLES=16 -> exactly two ReqValid pulses 17 cycles apart; DoneValid with status 01, DoneData 0.
- Response at timeout edge: the model returns the response exactly on the cycle the timer hits 0 -> status 00, no retry issued.
- Stray/illegal: inject a response while IDLE and one with a wrong address during WAIT -> StrayCnt=2 and the transaction still completes on the correct response. CmdOpcode=RD_RSP -> no ReqValid, status 10.
- Async reset asserted in WAIT -> all outputs 0 immediately. After release, CmdReady=1 one edge later and a new RD completes normally.

Source files
------------

// File: rtl/lotr_mmio_initiator.sv
// Fabric-side F2C MMIO initiator: issues one RD/WR request at a time,
// waits for the echoed RD_RSP, retries on timeout, counts stray responses.
module lotr_mmio_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned RETRY_MAX      = 1
) (
    input  logic        CLK_50,
    input  logic        RstQnnnH,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [1:0]  CmdOpcode,
    input  logic [31:0] CmdAddress,
    input  logic [31:0] CmdData,
    output logic        DoneValid,
    output logic [1:0]  DoneStatus,
    output logic [31:0] DoneData,
    output logic [7:0]  StrayCnt,
    output logic        F2C_ReqValidQ500H,
    output logic [1:0]  F2C_ReqOpcodeQ500H,
    output logic [31:0] F2C_ReqAddressQ500H,
    output logic [31:0] F2C_ReqDataQ500H,
    input  logic        F2C_RspValidQ502H,
    input  logic [1:0]  F2C_RspOpcodeQ502H,
    input  logic [31:0] F2C_RspAddressQ502H,
    input  logic [31:0] F2C_RspDataQ502H
);

    localparam logic [1:0] OP_RD     = 2'd0;
    localparam logic [1:0] OP_WR     = 2'd1;
    localparam logic [1:0] OP_RD_RSP = 2'd2;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    localparam int unsigned TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RETRY_W  = 3;
    localparam int unsigned OFFS_W   = 20;
    localparam int unsigned STRAY_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                done_valid_q, done_valid_d;
    logic [1:0]          done_status_q, done_status_d;
    logic [31:0]         done_data_q, done_data_d;
    logic [STRAY_W-1:0]  stray_q, stray_d;
    logic                req_valid_q, req_valid_d;
    logic [1:0]          req_op_q, req_op_d;
    logic [31:0]         req_addr_q, req_addr_d;
    logic [31:0]         req_data_q, req_data_d;
    logic [1:0]          cap_op_q, cap_op_d;
    logic [31:0]         cap_addr_q, cap_addr_d;
    logic [31:0]         cap_data_q, cap_data_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;

    logic                rsp_match;
    logic                rsp_consumed;
    logic                unused_rsp_addr_hi;

    // Upper response address bits are not part of the match
    assign unused_rsp_addr_hi = ^F2C_RspAddressQ502H[31:OFFS_W];

    // Response belongs to the outstanding request (CR offset compare only)
    assign rsp_match = F2C_RspValidQ502H
                     && (F2C_RspOpcodeQ502H == OP_RD_RSP)
                     && (F2C_RspAddressQ502H[OFFS_W-1:0] == cap_addr_q[OFFS_W-1:0]);

    // State and output registers
    always_ff @(posedge CLK_50 or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= '0;
            done_data_q   <= '0;
            stray_q       <= '0;
            req_valid_q   <= 1'b0;
            req_op_q      <= '0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            cap_op_q      <= '0;
            cap_addr_q    <= '0;
            cap_data_q    <= '0;
            timer_q       <= '0;
            retry_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
            done_data_q   <= done_data_d;
            stray_q       <= stray_d;
            req_valid_q   <= req_valid_d;
            req_op_q      <= req_op_d;
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            cap_op_q      <= cap_op_d;
            cap_addr_q    <= cap_addr_d;
            cap_data_q    <= cap_data_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = 1'b0;
        done_valid_d  = 1'b0;
        done_status_d = done_status_q;
        done_data_d   = done_data_q;
        req_valid_d   = 1'b0;
        req_op_d      = req_op_q;
        req_addr_d    = req_addr_q;
        req_data_d    = req_data_q;
        cap_op_d      = cap_op_q;
        cap_addr_d    = cap_addr_q;
        cap_data_d    = cap_data_q;
        timer_d       = timer_q;
        retry_d       = retry_q;
        rsp_consumed  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (CmdValid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cap_op_d    = CmdOpcode;
                    cap_addr_d  = CmdAddress;
                    cap_data_d  = CmdData;
                    if ((CmdOpcode == OP_RD) || (CmdOpcode == OP_WR)) begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_op_d    = CmdOpcode;
                        req_addr_d  = CmdAddress;
                        req_data_d  = CmdData;
                    end else begin
                        state_d       = S_DONE;
                        done_valid_d  = 1'b1;
                        done_status_d = ST_ILLEGAL;
                        done_data_d   = '0;
                    end
                end
            end

            S_REQ: begin
                timer_d = TIMER_W'(TIMEOUT_CYCLES);
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (rsp_match) begin
                    rsp_consumed  = 1'b1;
                    state_d       = S_DONE;
                    done_valid_d  = 1'b1;
                    done_status_d = ST_OK;
                    done_data_d   = (cap_op_q == OP_RD) ? F2C_RspDataQ502H : 32'h0;
                end else if (timer_q <= TIMER_W'(1)) begin
                    timer_d = '0;
                    if (retry_q < RETRY_W'(RETRY_MAX)) begin
                        retry_d     = retry_q + RETRY_W'(1);
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_op_d    = cap_op_q;
                        req_addr_d  = cap_addr_q;
                        req_data_d  = cap_data_q;
                    end else begin
                        state_d       = S_DONE;
                        done_valid_d  = 1'b1;
                        done_status_d = ST_TIMEOUT;
                        done_data_d   = '0;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            S_DONE: begin
                retry_d     = '0;
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        stray_d = stray_q;
        if (F2C_RspValidQ502H && !rsp_consumed && (stray_q != {STRAY_W{1'b1}})) begin
            stray_d = stray_q + STRAY_W'(1);
        end
    end

    assign CmdReady            = cmd_ready_q;
    assign DoneValid           = done_valid_q;
    assign DoneStatus          = done_status_q;
    assign DoneData            = done_data_q;
    assign StrayCnt            = stray_q;
    assign F2C_ReqValidQ500H   = req_valid_q;
    assign F2C_ReqOpcodeQ500H  = req_op_q;
    assign F2C_ReqAddressQ500H = req_addr_q;
    assign F2C_ReqDataQ500H    = req_data_q;

endmodule

// File: tb/tb_lotr_mmio_initiator.sv
// Bench for lotr_mmio_initiator with a small DE10-Lite responder model.
module tb_lotr_mmio_initiator;

    localparam logic [1:0] OP_RD     = 2'd0;
    localparam logic [1:0] OP_WR     = 2'd1;
    localparam logic [1:0] OP_RD_RSP = 2'd2;
    localparam logic [1:0] OP_BAD    = 2'd3;

    localparam logic [31:0] ADDR_LED = 32'h0000_0010;
    localparam logic [31:0] ADDR_SW  = 32'h0000_0020;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        done_valid;
    logic [1:0]  done_status;
    logic [31:0] done_data;
    logic [7:0]  stray_cnt;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_data;

    lotr_mmio_initiator #(
        .TIMEOUT_CYCLES(16),
        .RETRY_MAX     (1)
    ) dut (
        .CLK_50              (clk),
        .RstQnnnH            (rst_n),
        .CmdValid            (cmd_valid),
        .CmdReady            (cmd_ready),
        .CmdOpcode           (cmd_op),
        .CmdAddress          (cmd_addr),
        .CmdData             (cmd_data),
        .DoneValid           (done_valid),
        .DoneStatus          (done_status),
        .DoneData            (done_data),
        .StrayCnt            (stray_cnt),
        .F2C_ReqValidQ500H   (req_valid),
        .F2C_ReqOpcodeQ500H  (req_op),
        .F2C_ReqAddressQ500H (req_addr),
        .F2C_ReqDataQ500H    (req_data),
        .F2C_RspValidQ502H   (rsp_valid),
        .F2C_RspOpcodeQ502H  (rsp_op),
        .F2C_RspAddressQ502H (rsp_addr),
        .F2C_RspDataQ502H    (rsp_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    // responder model state
    int          rsp_lat  = 3;          // 0 = drop every response
    logic [31:0] rsp_axor = 32'h0;      // flips echoed upper address bits
    int          pend_cyc = -1;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    int          inj_cyc  = -1;
    logic [31:0] inj_addr;
    logic [31:0] led_reg  = 32'h0;
    logic [31:0] sw_reg   = 32'h0000_02A5;

    // observation trackers
    int          req_count;
    int          req_cyc0;
    int          req_cyc1;
    int          done_seen;
    int          done_cyc;
    logic [1:0]  obs_status;
    logic [31:0] obs_data;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] axor;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_reqs;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe DUT outputs, run the responder, drive response pins
    task automatic tick();
        logic [19:0] off;
        @(posedge clk);
        #1;
        cyc++;
        if (req_valid === 1'b1) begin
            if (req_count == 0) req_cyc0 = cyc;
            else if (req_count == 1) req_cyc1 = cyc;
            req_count++;
            off = req_addr[19:0];
            pend_data = 32'h0;
            if (req_op == OP_WR) begin
                if (off == ADDR_LED[19:0]) led_reg = req_data;
            end else begin
                if (off == ADDR_LED[19:0])     pend_data = led_reg;
                else if (off == ADDR_SW[19:0]) pend_data = sw_reg;
                else                           pend_data = {12'hDEA, off};
            end
            pend_addr = req_addr ^ rsp_axor;
            if (rsp_lat > 0) pend_cyc = cyc + rsp_lat;
        end
        if (done_valid === 1'b1) begin
            done_seen++;
            done_cyc   = cyc;
            obs_status = done_status;
            obs_data   = done_data;
        end
        rsp_valid = 1'b0;
        rsp_op    = OP_RD_RSP;
        rsp_addr  = 32'h0;
        rsp_data  = 32'h0;
        if (cyc == pend_cyc) begin
            rsp_valid = 1'b1;
            rsp_addr  = pend_addr;
            rsp_data  = pend_data;
        end else if (cyc == inj_cyc) begin
            rsp_valid = 1'b1;
            rsp_addr  = inj_addr;
            rsp_data  = 32'hBAD0_BAD0;
        end
    endtask

    // Issue one command and wait (bounded) for its completion
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                           output int lat);
        int n;
        int t0;
        req_count = 0;
        done_seen = 0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        t0 = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 32'h0;
        cmd_data  = 32'h0;
        n = 0;
        while (done_seen == 0 && n < 100) begin
            tick();
            n++;
        end
        lat = (done_seen != 0) ? (done_cyc - t0) : -1;
        if (done_seen == 0) begin
            obs_status = 2'bxx;
            obs_data   = 32'hxxxx_xxxx;
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{OP_WR,     ADDR_LED,      32'h0000_03FF, 3, 32'h0,         2'b00, 32'h0,         5, 1};
        vecs[1] = '{OP_RD,     ADDR_SW,       32'h0,         3, 32'h0,         2'b00, 32'h0000_02A5, 5, 1};
        vecs[2] = '{OP_RD,     ADDR_LED,      32'h0,         3, 32'h0,         2'b00, 32'h0000_03FF, 5, 1};
        vecs[3] = '{OP_RD,     32'hABC0_0020, 32'h0,         3, 32'hFFF0_0000, 2'b00, 32'h0000_02A5, 5, 1};
        vecs[4] = '{OP_WR,     ADDR_LED,      32'h0000_0155, 5, 32'h0,         2'b00, 32'h0,         7, 1};
        vecs[5] = '{OP_BAD,    ADDR_SW,       32'h1234_5678, 3, 32'h0,         2'b10, 32'h0,         1, 0};
        vecs[6] = '{OP_RD_RSP, ADDR_LED,      32'h0,         3, 32'h0,         2'b10, 32'h0,         1, 0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 32'h0;
        cmd_data  = 32'h0;
        rsp_valid = 1'b0;
        rsp_op    = OP_RD_RSP;
        rsp_addr  = 32'h0;
        rsp_data  = 32'h0;
        req_count = 0;
        done_seen = 0;

        // reset values
        @(posedge clk);
        #1;
        check("rst_cmd_ready",  32'(cmd_ready),  32'h0);
        check("rst_req_valid",  32'(req_valid),  32'h0);
        check("rst_done_valid", 32'(done_valid), 32'h0);
        check("rst_stray",      32'(stray_cnt),  32'h0);
        check("rst_req_addr",   req_addr,        32'h0);
        rst_n = 1'b1;
        #2;
        check("rst_rel_ready_pre_edge", 32'(cmd_ready), 32'h0);
        tick();
        check("rst_rel_ready_post_edge", 32'(cmd_ready), 32'h1);

        // table-driven transactions
        for (int i = 0; i < 7; i++) begin
            rsp_lat  = vecs[i].lat;
            rsp_axor = vecs[i].axor;
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, lat);
            check($sformatf("vec%0d_status", i), 32'(obs_status), 32'(vecs[i].exp_status));
            check($sformatf("vec%0d_data", i),   obs_data,        vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), 32'(lat),       32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_reqs", i),   32'(req_count),  32'(vecs[i].exp_reqs));
            check($sformatf("vec%0d_stray", i),  32'(stray_cnt),  32'h0);
        end
        rsp_axor = 32'h0;

        // lost response: two requests 17 apart, then timeout
        rsp_lat = 0;
        run_cmd(OP_RD, ADDR_SW, 32'h0, lat);
        check("lost_status",  32'(obs_status),         32'h1);
        check("lost_data",    obs_data,                32'h0);
        check("lost_reqs",    32'(req_count),          32'h2);
        check("lost_spacing", 32'(req_cyc1 - req_cyc0), 32'd17);
        check("lost_latency", 32'(lat),                32'd35);
        check("lost_stray",   32'(stray_cnt),          32'h0);

        // response on the exact cycle the timer expires wins
        rsp_lat = 16;
        run_cmd(OP_RD, ADDR_SW, 32'h0, lat);
        for (int k = 0; k < 20; k++) tick();
        check("edge_status",  32'(obs_status), 32'h0);
        check("edge_data",    obs_data,        32'h0000_02A5);
        check("edge_latency", 32'(lat),        32'd18);
        check("edge_reqs",    32'(req_count),  32'h1);
        check("edge_stray",   32'(stray_cnt),  32'h0);

        // stray response while idle
        rsp_lat  = 3;
        inj_addr = ADDR_SW;
        inj_cyc  = cyc + 1;
        tick();
        tick();
        check("stray_idle", 32'(stray_cnt), 32'h1);

        // wrong-address response during WAIT, then correct completion
        tick();
        inj_addr = ADDR_LED;
        inj_cyc  = cyc + 2;
        run_cmd(OP_RD, ADDR_SW, 32'h0, lat);
        tick();
        check("stray_wait_status",  32'(obs_status), 32'h0);
        check("stray_wait_data",    obs_data,        32'h0000_02A5);
        check("stray_wait_latency", 32'(lat),        32'd5);
        check("stray_wait_cnt",     32'(stray_cnt),  32'h2);

        // late duplicate after a retry is counted as stray
        rsp_lat = 17;
        run_cmd(OP_RD, ADDR_SW, 32'h0, lat);
        for (int k = 0; k < 20; k++) tick();
        check("late_status", 32'(obs_status), 32'h1);
        check("late_reqs",   32'(req_count),  32'h2);
        check("late_stray",  32'(stray_cnt),  32'h3);

        // async reset in WAIT aborts the transaction
        rsp_lat   = 0;
        req_count = 0;
        done_seen = 0;
        while (cmd_ready !== 1'b1 && req_count < 20) tick();
        cmd_valid = 1'b1;
        cmd_op    = OP_RD;
        cmd_addr  = ADDR_SW;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("abort_in_wait_req_seen", 32'(req_count), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready",  32'(cmd_ready),  32'h0);
        check("abort_req_valid",  32'(req_valid),  32'h0);
        check("abort_req_addr",   req_addr,        32'h0);
        check("abort_done_valid", 32'(done_valid), 32'h0);
        check("abort_stray",      32'(stray_cnt),  32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        check("abort_ready_pre_edge", 32'(cmd_ready), 32'h0);
        tick();
        check("abort_ready_post_edge", 32'(cmd_ready), 32'h1);
        check("abort_no_done", 32'(done_seen), 32'h0);

        rsp_lat = 3;
        run_cmd(OP_RD, ADDR_SW, 32'h0, lat);
        check("post_rst_status",  32'(obs_status), 32'h0);
        check("post_rst_data",    obs_data,        32'h0000_02A5);
        check("post_rst_latency", 32'(lat),        32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
